// File: rtl/nanorv32_lsu_if.sv
// Data memory bus between the nanorv32 LSU (master) and data memory (slave).
// The request side is registered in the LSU. The response side is sampled only while valid is high.
interface nanorv32_lsu_if #(
    parameter int NANORV32_ADDR_MSB = 31
) ();
    logic [NANORV32_ADDR_MSB:0] cpu_datamem_addr;
    logic [31:0]                cpu_datamem_wdata;
    logic [3:0]                 cpu_datamem_bytesel;
    logic                       cpu_datamem_valid;
    logic [31:0]                datamem_cpu_rdata;
    logic                       datamem_cpu_ready;

    modport master (
        output cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_valid,
        input  datamem_cpu_rdata, datamem_cpu_ready
    );

    modport slave (
        input  cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_valid,
        output datamem_cpu_rdata, datamem_cpu_ready
    );
endinterface

// File: rtl/nanorv32_lsu.sv
// nanorv32 load/store unit: formats stores into byte lanes and runs the data memory handshake.
// It also aligns and extends load data, and stalls the core until each access retires.
//   state | meaning
//   IDLE  | waiting for a request; misaligned requests are rejected here
//   BUSY  | bus request active, waiting for datamem_cpu_ready
//   DONE  | access retired, load result valid, core advances
module nanorv32_lsu #(
    parameter int NANORV32_ADDR_MSB = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lsu_req_valid,
    input  logic                       lsu_req_we,
    input  logic [1:0]                 lsu_req_size,
    input  logic                       lsu_req_unsigned,
    input  logic [NANORV32_ADDR_MSB:0] lsu_req_addr,
    input  logic [31:0]                lsu_req_wdata,
    output logic                       lsu_stall,
    output logic [31:0]                lsu_rdata,
    output logic                       lsu_rdata_valid,
    output logic                       lsu_misaligned,
    nanorv32_lsu_if.master             mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        misaligned_req;
    logic        accept;
    logic [3:0]  lane_bytesel;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    always_comb begin
        misaligned_req = 1'b0;
        case (lsu_req_size)
            2'b00:   misaligned_req = 1'b0;
            2'b01:   misaligned_req = lsu_req_addr[0];
            2'b10:   misaligned_req = |lsu_req_addr[1:0];
            default: misaligned_req = 1'b1;
        endcase
    end

    // Gated by rst_n so that an asserted reset clears the pulses even if the request is held.
    assign accept         = (state == IDLE) && lsu_req_valid && !misaligned_req;
    assign lsu_misaligned = rst_n && (state == IDLE) && lsu_req_valid && misaligned_req;
    assign lsu_stall      = rst_n && (accept || (state == BUSY));

    always_comb begin
        lane_bytesel = 4'b0000;
        lane_wdata   = 32'h0;
        case (lsu_req_size)
            2'b00: begin
                lane_bytesel = 4'b0001 << lsu_req_addr[1:0];
                lane_wdata   = {4{lsu_req_wdata[7:0]}};
            end
            2'b01: begin
                lane_bytesel = lsu_req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata   = {2{lsu_req_wdata[15:0]}};
            end
            default: begin
                lane_bytesel = 4'b1111;
                lane_wdata   = lsu_req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted  = mem.datamem_cpu_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            off_q                   <= 2'b00;
            size_q                  <= 2'b00;
            uns_q                   <= 1'b0;
            we_q                    <= 1'b0;
            lsu_rdata               <= 32'h0;
            lsu_rdata_valid         <= 1'b0;
            mem.cpu_datamem_addr    <= '0;
            mem.cpu_datamem_wdata   <= 32'h0;
            mem.cpu_datamem_bytesel <= 4'b0000;
            mem.cpu_datamem_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lsu_rdata_valid <= 1'b0;
                    if (accept) begin
                        off_q                   <= lsu_req_addr[1:0];
                        size_q                  <= lsu_req_size;
                        uns_q                   <= lsu_req_unsigned;
                        we_q                    <= lsu_req_we;
                        mem.cpu_datamem_addr    <= {lsu_req_addr[NANORV32_ADDR_MSB:2], 2'b00};
                        mem.cpu_datamem_wdata   <= lsu_req_we ? lane_wdata : 32'h0;
                        mem.cpu_datamem_bytesel <= lsu_req_we ? lane_bytesel : 4'b0000;
                        mem.cpu_datamem_valid   <= 1'b1;
                        state                   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem.datamem_cpu_ready) begin
                        mem.cpu_datamem_valid <= 1'b0;
                        state                 <= DONE;
                        if (!we_q) begin
                            lsu_rdata       <= load_ext;
                            lsu_rdata_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    lsu_rdata_valid <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
